// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode encodings and request payload type for the ALU arbiter slice.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ALUOP_W = 4;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADDU = 4'd0,
    ALU_SUBU = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_LUI  = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_NOR  = 4'd11,
    ALU_XXX  = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [ALUOP_W-1:0] op;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// MIPS150 ALU: combinational, shift amount is the full A operand, unknown opcodes give 0.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0]  i_a,
  input  logic [DATA_W-1:0]  i_b,
  input  logic [ALUOP_W-1:0] i_op,
  output logic [DATA_W-1:0]  o_out_c
);

  always_comb begin
    o_out_c = '0;
    case (i_op)
      ALU_ADDU: o_out_c = i_a + i_b;
      ALU_SUBU: o_out_c = i_a - i_b;
      ALU_SLT:  o_out_c = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_out_c = {{(DATA_W-1){1'b0}}, (i_a < i_b)};
      ALU_AND:  o_out_c = i_a & i_b;
      ALU_OR:   o_out_c = i_a | i_b;
      ALU_XOR:  o_out_c = i_a ^ i_b;
      ALU_LUI:  o_out_c = {i_b[15:0], 16'h0000};
      ALU_SLL:  o_out_c = i_b << i_a;
      ALU_SRL:  o_out_c = i_b >> i_a;
      ALU_SRA:  o_out_c = $unsigned($signed(i_b) >>> i_a);
      ALU_NOR:  o_out_c = ~(i_a | i_b);
      default:  o_out_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_rr.sv
// Round-robin arbiter: search starts at the pointer and wraps; pointer moves past the winner on advance.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  localparam int unsigned SUM_W = ID_W + 1;

  logic [ID_W-1:0]  r_ptr;
  logic [SUM_W-1:0] w_sum;
  logic [ID_W-1:0]  w_idx;
  logic             w_found;

  // First valid requester at or after the pointer, modulo N.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    w_sum    = '0;
    w_idx    = '0;
    w_found  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + SUM_W'(k);
      if (w_sum >= SUM_W'(N)) w_sum = w_sum - SUM_W'(N);
      w_idx = w_sum[ID_W-1:0];
      if (!w_found && req[w_idx]) begin
        w_found     = 1'b1;
        grant[w_idx] = 1'b1;
        grant_id    = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance && |req) begin
      r_ptr <= (grant_id == ID_W'(N - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters: RR arbitration, operand stage, ALU, result stage.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [DATA_W*NUM_REQ-1:0]   req_A,
  input  logic [DATA_W*NUM_REQ-1:0]   req_B,
  input  logic [ALUOP_W*NUM_REQ-1:0]  req_ALUop,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [ID_W-1:0]             resp_id,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        busy
);

  logic               w_s1_adv;
  logic               w_s2_adv;
  logic               w_xfer;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_gid;
  alu_req_t           w_req;
  logic [DATA_W-1:0]  w_alu_out;

  logic               r_s1_valid;
  alu_req_t           r_s1;
  logic [ID_W-1:0]    r_s1_id;
  logic               r_resp_valid;
  logic [ID_W-1:0]    r_resp_id;
  logic [DATA_W-1:0]  r_resp_data;

  assign w_s2_adv  = !r_resp_valid || resp_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  // Accept is held low while reset is asserted.
  assign req_ready = w_grant & {NUM_REQ{w_s1_adv & rst_n}};
  assign w_xfer    = |req_ready;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .advance  (w_s1_adv),
    .grant    (w_grant),
    .grant_id (w_gid)
  );

  // Select the winning requester's operands.
  always_comb begin
    w_req = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gid == ID_W'(i)) begin
        w_req.a  = req_A[DATA_W*i +: DATA_W];
        w_req.b  = req_B[DATA_W*i +: DATA_W];
        w_req.op = req_ALUop[ALUOP_W*i +: ALUOP_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
      r_s1_id    <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_xfer;
      r_s1       <= w_req;
      r_s1_id    <= w_gid;
    end
  end

  alu u_alu (
    .i_a     (r_s1.a),
    .i_b     (r_s1.b),
    .i_op    (r_s1.op),
    .o_out_c (w_alu_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
    end else if (w_s2_adv) begin
      r_resp_valid <= r_s1_valid;
      r_resp_id    <= r_s1_id;
      r_resp_data  <= w_alu_out;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign busy       = r_s1_valid | r_resp_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single-op vector table plus round-robin, backpressure and reset sequences.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_A;
  logic [127:0] req_B;
  logic [15:0]  req_ALUop;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [31:0]  resp_data;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_A      (req_A),
    .req_B      (req_B),
    .req_ALUop  (req_ALUop),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  typedef struct {
    logic [1:0]  id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req_A[32*i +: 32]    = a;
    req_B[32*i +: 32]    = b;
    req_ALUop[4*i +: 4]  = op;
    req_valid[i]         = 1'b1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  vec_t vecs[16];

  initial begin
    logic [3:0] oh;
    vecs = '{
      '{2'd2, 32'd5,          32'd3,          ALU_SUBU, 32'd2},
      '{2'd0, 32'hFFFFFFFF,   32'd1,          ALU_SLT,  32'd1},
      '{2'd1, 32'hFFFFFFFF,   32'd1,          ALU_SLTU, 32'd0},
      '{2'd3, 32'd4,          32'h80000000,   ALU_SRA,  32'hF8000000},
      '{2'd1, 32'd7,          32'd9,          ALU_XXX,  32'd0},
      '{2'd0, 32'd7,          32'd9,          ALU_ADDU, 32'd16},
      '{2'd3, 32'hF0F0F0F0,   32'hFF00FF00,   ALU_AND,  32'hF000F000},
      '{2'd2, 32'hF0F0F0F0,   32'hFF00FF00,   ALU_OR,   32'hFFF0FFF0},
      '{2'd1, 32'hF0F0F0F0,   32'hFF00FF00,   ALU_XOR,  32'h0FF00FF0},
      '{2'd0, 32'hF0F0F0F0,   32'hFF00FF00,   ALU_NOR,  32'h000F000F},
      '{2'd3, 32'd0,          32'h00001234,   ALU_LUI,  32'h12340000},
      '{2'd2, 32'd4,          32'd1,          ALU_SLL,  32'd16},
      '{2'd1, 32'd33,         32'hFFFFFFFF,   ALU_SRL,  32'd0},
      '{2'd0, 32'd40,         32'h80000000,   ALU_SRA,  32'hFFFFFFFF},
      '{2'd2, 32'd3,          32'd5,          ALU_SUBU, 32'hFFFFFFFE},
      '{2'd0, 32'd1,          32'hFFFFFFFF,   ALU_ADDU, 32'd0}
    };

    req_A      = '0;
    req_B      = '0;
    req_ALUop  = '0;
    resp_ready = 1'b1;

    // Reset state; accept must be low while reset is asserted even with requests pending.
    rst_n     = 1'b0;
    req_valid = 4'hF;
    tick();
    check("rst_ready", req_ready, 4'h0);
    tick();
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_id", resp_id, 2'd0);
    rst_n     = 1'b1;
    req_valid = '0;
    tick();

    // Single-op vectors: accept same cycle, result two edges after transfer.
    for (int n = 0; n < 16; n++) begin
      req_valid = '0;
      set_req(vecs[n].id, vecs[n].a, vecs[n].b, vecs[n].op);
      oh = 4'b0001 << vecs[n].id;
      #1;
      check($sformatf("v%0d_ready", n), req_ready, oh);
      tick();
      req_valid = '0;
      check($sformatf("v%0d_early", n), resp_valid, 1'b0);
      tick();
      check($sformatf("v%0d_valid", n), resp_valid, 1'b1);
      check($sformatf("v%0d_id", n), resp_id, vecs[n].id);
      check($sformatf("v%0d_data", n), resp_data, vecs[n].exp);
      tick();
      check($sformatf("v%0d_idle", n), busy, 1'b0);
    end

    // Round-robin with all requesters continuously valid, back-to-back results.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'(i), 32'd10, ALU_ADDU);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c < 8) check($sformatf("rr%0d_ready", c), req_ready, 4'b0001 << (c % 4));
      if (c >= 2) begin
        check($sformatf("rr%0d_valid", c), resp_valid, 1'b1);
        check($sformatf("rr%0d_id", c), resp_id, 32'((c - 2) % 4));
        check($sformatf("rr%0d_data", c), resp_data, 32'(10 + (c - 2) % 4));
      end
      tick();
    end
    req_valid = '0;
    tick(); tick(); tick();

    // Backpressure: two ops buffered, accept stalls, result held stable.
    do_reset();
    resp_ready = 1'b0;
    set_req(0, 32'd100, 32'd1, ALU_ADDU);
    set_req(1, 32'd200, 32'd2, ALU_ADDU);
    #1;
    check("bp_ready0", req_ready, 4'b0001);
    tick();
    check("bp_ready1", req_ready, 4'b0010);
    tick();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_stall%0d_ready", c), req_ready, 4'b0000);
      check($sformatf("bp_stall%0d_valid", c), resp_valid, 1'b1);
      check($sformatf("bp_stall%0d_data", c), resp_data, 32'd101);
      check($sformatf("bp_stall%0d_id", c), resp_id, 2'd0);
      check($sformatf("bp_stall%0d_busy", c), busy, 1'b1);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_drain_ready", req_ready, 4'b0001);
    check("bp_drain_data0", resp_data, 32'd101);
    tick();
    check("bp_drain_data1", resp_data, 32'd202);
    check("bp_drain_id1", resp_id, 2'd1);
    check("bp_drain_ready1", req_ready, 4'b0010);
    tick();
    check("bp_third_data", resp_data, 32'd101);
    check("bp_third_id", resp_id, 2'd0);
    req_valid = '0;
    tick(); tick(); tick();

    // Reset with both stages full; no stale response, pointer back at 0.
    resp_ready = 1'b0;
    set_req(0, 32'd1, 32'd1, ALU_ADDU);
    set_req(1, 32'd2, 32'd2, ALU_ADDU);
    tick();
    tick();
    check("mr_full_busy", busy, 1'b1);
    check("mr_full_valid", resp_valid, 1'b1);
    set_req(2, 32'd3, 32'd3, ALU_ADDU);
    rst_n = 1'b0;
    #1;
    check("mr_rst_ready", req_ready, 4'b0000);
    tick();
    rst_n     = 1'b1;
    req_valid = '0;
    check("mr_post_valid", resp_valid, 1'b0);
    check("mr_post_busy", busy, 1'b0);
    resp_ready = 1'b1;
    for (int i = 3; i >= 0; i--) set_req(i, 32'(i), 32'd50, ALU_ADDU);
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c < 4) check($sformatf("mr%0d_ready", c), req_ready, 4'b0001 << c);
      if (c < 2) begin
        check($sformatf("mr%0d_nostale", c), resp_valid, 1'b0);
      end else begin
        check($sformatf("mr%0d_valid", c), resp_valid, 1'b1);
        check($sformatf("mr%0d_id", c), resp_id, 32'(c - 2));
        check($sformatf("mr%0d_data", c), resp_data, 32'(50 + c - 2));
      end
      tick();
    end
    req_valid = '0;
    tick(); tick(); tick();
    check("end_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
